// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter for the shared GPR write port, with a registered write
// stage and a pending-write scoreboard that decode uses for hazard stalls.
module gpr_wb_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GPRS_WIDTH = 5,
    parameter int unsigned NUM_REQ    = 3
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [NUM_REQ-1:0]               i_req_valid,
    output logic [NUM_REQ-1:0]               o_req_ready,
    input  logic [NUM_REQ*GPRS_WIDTH-1:0]    i_req_id,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
    input  logic                             i_iss_en,
    input  logic [GPRS_WIDTH-1:0]            i_iss_id,
    output logic [31:0]                      o_busy,
    output logic                             o_gpr_wr_en,
    output logic [GPRS_WIDTH-1:0]            o_gpr_wr_id,
    output logic [DATA_WIDTH-1:0]            o_gpr_wr_data
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]      last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0]    grant;
    logic                  found;
    logic [PTR_W-1:0]      idx;
    logic [GPRS_WIDTH-1:0] win_id;
    logic [DATA_WIDTH-1:0] win_data;

    logic                  wr_en_q;
    logic [GPRS_WIDTH-1:0] wr_id_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [31:0]           busy_q, busy_d;

    // Walk the requesters starting one past the last winner, wrapping.
    always_comb begin
        grant        = '0;
        found        = 1'b0;
        idx          = last_grant_q;
        last_grant_d = last_grant_q;
        win_id       = '0;
        win_data     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (idx == PTR_LAST) ? '0 : idx + 1'b1;
            if (!found && i_req_valid[idx]) begin
                found        = 1'b1;
                grant[idx]   = 1'b1;
                last_grant_d = idx;
                win_id       = i_req_id[idx*GPRS_WIDTH +: GPRS_WIDTH];
                win_data     = i_req_data[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign o_req_ready = i_rst_n ? grant : '0;

    // A younger issue to the same register must survive a same-edge commit.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_id_q] = 1'b0;
        end
        if (i_iss_en && (i_iss_id != '0)) begin
            busy_d[i_iss_id] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_grant_q <= PTR_LAST;
            wr_en_q      <= 1'b0;
            wr_id_q      <= '0;
            wr_data_q    <= '0;
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= found && (win_id != '0);
            if (found) begin
                wr_id_q   <= win_id;
                wr_data_q <= win_data;
            end
            busy_q <= busy_d;
        end
    end

    assign o_busy        = busy_q;
    assign o_gpr_wr_en   = wr_en_q;
    assign o_gpr_wr_id   = wr_id_q;
    assign o_gpr_wr_data = wr_data_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: reset, round-robin order, x0 drop,
// scoreboard set/clear interactions and reset in mid-operation.
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_id;
    logic [95:0] req_data;
    logic        iss_en;
    logic [4:0]  iss_id;
    logic [31:0] busy;
    logic        wr_en;
    logic [4:0]  wr_id;
    logic [31:0] wr_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(.DATA_WIDTH(32), .GPRS_WIDTH(5), .NUM_REQ(3)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_id      (req_id),
        .i_req_data    (req_data),
        .i_iss_en      (iss_en),
        .i_iss_id      (iss_id),
        .o_busy        (busy),
        .o_gpr_wr_en   (wr_en),
        .o_gpr_wr_id   (wr_id),
        .o_gpr_wr_data (wr_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [4:0] id, input logic [31:0] data);
        req_id[k*5 +: 5]     = id;
        req_data[k*32 +: 32] = data;
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_id    = '0;
        req_data  = '0;
        iss_en    = 1'b0;
        iss_id    = '0;
        set_req(0, 5'd1, 32'hA0);
        set_req(1, 5'd2, 32'hA1);
        set_req(2, 5'd3, 32'hA2);

        cyc();
        cyc();
        check_eq("rst_ready", req_ready, 3'b000);
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_wr_id", wr_id, 5'd0);
        check_eq("rst_wr_data", wr_data, 32'd0);
        check_eq("rst_busy", busy, 32'd0);

        // Contention: grants 0,1,2,0,1,2, each written out one cycle later.
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check_eq($sformatf("rr_ready_%0d", c), req_ready, 3'b001 << (c % 3));
            cyc();
            check_eq($sformatf("rr_wr_en_%0d", c), wr_en, 1'b1);
            check_eq($sformatf("rr_wr_id_%0d", c), wr_id, 5'(c % 3 + 1));
            check_eq($sformatf("rr_wr_data_%0d", c), wr_data, 32'hA0 + 32'(c % 3));
        end

        // Idle: no write, id/data hold.
        req_valid = 3'b000;
        #1;
        check_eq("idle_ready", req_ready, 3'b000);
        cyc();
        check_eq("idle_wr_en", wr_en, 1'b0);
        check_eq("idle_wr_id", wr_id, 5'd3);
        check_eq("idle_wr_data", wr_data, 32'hA2);

        // Single request from requester 1.
        set_req(1, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        check_eq("single_ready", req_ready, 3'b010);
        cyc();
        req_valid = 3'b000;
        check_eq("single_wr_en", wr_en, 1'b1);
        check_eq("single_wr_id", wr_id, 5'd5);
        check_eq("single_wr_data", wr_data, 32'hDEADBEEF);
        cyc();
        check_eq("single_wr_en_off", wr_en, 1'b0);

        // x0 write: accepted, loaded, but no write enable.
        set_req(2, 5'd0, 32'h1234);
        req_valid = 3'b100;
        #1;
        check_eq("x0_ready", req_ready, 3'b100);
        cyc();
        req_valid = 3'b000;
        check_eq("x0_wr_en", wr_en, 1'b0);
        check_eq("x0_wr_data", wr_data, 32'h1234);
        check_eq("x0_busy", busy, 32'd0);

        // Scoreboard set then commit clear.
        iss_en = 1'b1;
        iss_id = 5'd7;
        cyc();
        iss_en = 1'b0;
        check_eq("sb_set7", busy, 32'h80);
        set_req(0, 5'd7, 32'h77);
        req_valid = 3'b001;
        #1;
        check_eq("sb_w7_ready", req_ready, 3'b001);
        cyc();
        req_valid = 3'b000;
        check_eq("sb_w7_en", wr_en, 1'b1);
        check_eq("sb_w7_busy_before", busy, 32'h80);
        cyc();
        check_eq("sb_w7_clear", busy, 32'h0);

        // Same-edge set and clear of x7: set wins.
        iss_en = 1'b1;
        iss_id = 5'd7;
        cyc();
        iss_en = 1'b0;
        req_valid = 3'b001;
        #1;
        check_eq("sb_wrap_ready", req_ready, 3'b001);
        cyc();
        req_valid = 3'b000;
        check_eq("sb_same_wr_en", wr_en, 1'b1);
        iss_en = 1'b1;
        iss_id = 5'd7;
        cyc();
        iss_en = 1'b0;
        check_eq("sb_same_set_wins", busy, 32'h80);

        // Clear x7 while setting x12 on the same edge.
        req_valid = 3'b001;
        cyc();
        req_valid = 3'b000;
        iss_en = 1'b1;
        iss_id = 5'd12;
        cyc();
        check_eq("sb_diff_idx", busy, 32'h1000);
        iss_id = 5'd0;
        cyc();
        iss_en = 1'b0;
        check_eq("sb_iss_x0", busy, 32'h1000);

        // Reset in the cycle after a handshake on x9.
        iss_en = 1'b1;
        iss_id = 5'd9;
        cyc();
        iss_en = 1'b0;
        check_eq("mid_busy9", busy, 32'h1200);
        set_req(1, 5'd9, 32'h99);
        req_valid = 3'b010;
        #1;
        check_eq("mid_ready", req_ready, 3'b010);
        cyc();
        rst_n     = 1'b0;
        req_valid = 3'b111;
        check_eq("mid_wr_en_pre", wr_en, 1'b1);
        #1;
        check_eq("mid_rst_ready", req_ready, 3'b000);
        cyc();
        check_eq("mid_wr_en_rst", wr_en, 1'b0);
        check_eq("mid_busy_rst", busy, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("mid_release_ready", req_ready, 3'b001);
        cyc();
        req_valid = 3'b000;
        check_eq("mid_release_wr_id", wr_id, 5'd7);
        check_eq("mid_release_wr_data", wr_data, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Shares the single GPR write port between NUM_REQ writeback requesters (ALU, LSU, CSR/MUL) using round-robin arbitration with valid/ready handshakes.
- Registers the winning request into a one-stage output that drives the register file write port directly.
- Keeps a 32-bit pending-write scoreboard: issue sets a busy bit, commit clears it. Decode uses the scoreboard for hazard stalls.

Parameters:
- DATA_WIDTH, 32, width of write data.
- GPRS_WIDTH, 5, width of the register index.
- NUM_REQ, 3, number of writeback requesters (2..8).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_req_valid  input  NUM_REQ  per-requester write request valid.
- o_req_ready  output  NUM_REQ  per-requester grant/accept (one-hot or zero).
- i_req_id  input  NUM_REQ*GPRS_WIDTH  packed destination indices; requester k occupies slice k.
- i_req_data  input  NUM_REQ*DATA_WIDTH  packed write data; requester k occupies slice k.
- i_iss_en  input  1  issue of an instruction that will write a GPR.
- i_iss_id  input  GPRS_WIDTH  destination of the issuing instruction.
- o_busy  output  32  bit n = 1: write to xn pending.
- o_gpr_wr_en  output  1  write enable to register file.
- o_gpr_wr_id  output  GPRS_WIDTH  write index to register file.
- o_gpr_wr_data  output  DATA_WIDTH  write data to register file.

Behaviour:
- Reset: synchronous on a rising edge of i_clk while i_rst_n=0.
  - o_gpr_wr_en=0, o_gpr_wr_id=0, o_gpr_wr_data=0, o_busy=0.
  - RR pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
  - o_req_ready=0 while i_rst_n=0.
- Arbitration (combinational within the cycle):
  - Search i_req_valid starting at (last_grant+1) mod NUM_REQ, wrapping.
  - The first valid requester found gets o_req_ready=1; all other ready bits are 0.
  - A handshake occurs when valid&ready are both high. The requester must hold id/data stable until its handshake.
  - last_grant updates to the winner only on a handshake. With no valid requests the pointer holds.
  - The output stage never back-pressures: the register file write always completes, so one request is accepted every cycle any valid is high.
- Output stage (latency 1 cycle):
  - At the handshake edge, o_gpr_wr_id/o_gpr_wr_data load the winner's id/data.
  - o_gpr_wr_en = 1 if the winner's id != 0, else 0. An x0 request is accepted and dropped.
  - In a cycle with no handshake, o_gpr_wr_en=0 and id/data hold their previous values.
- Scoreboard:
  - Set: i_iss_en=1 with i_iss_id!=0 sets o_busy[i_iss_id] at the next edge. Issue to x0 is ignored; o_busy[0] is always 0.
  - Clear: on the edge that ends a cycle with o_gpr_wr_en=1, o_busy[o_gpr_wr_id] is cleared. This is the same edge at which the register file latches the data.
  - Same-edge set and clear of the same index: set wins, because the new issue is younger.
  - Set and clear of different indices on the same edge both take effect.
  - A clear of an index whose busy bit is already 0 has no effect and is not an error.
- Reset mid-operation: the registered write is discarded (o_gpr_wr_en=0 next cycle), all busy bits clear, and the pointer returns to NUM_REQ-1.
- Width rules: id/data slices are taken as [k*W +: W]. No arithmetic beyond the pointer increment mod NUM_REQ.

Test Plan:
- Reset values: hold i_rst_n=0 for 2 cycles with all valids high -> o_req_ready=000, o_gpr_wr_en=0, o_busy=0. The first cycle after release grants requester 0.
- Single request: req1 valid, id=5, data=0xDEADBEEF -> o_req_ready=010 the same cycle. Next cycle o_gpr_wr_en=1, id=5, data=0xDEADBEEF. The following cycle o_gpr_wr_en=0.
- Contention: all 3 valid continuously for 6 cycles -> grant order 0,1,2,0,1,2. Output writes appear in that order, one cycle delayed.
- x0 drop: req2 writes id=0, data=0x1234 -> handshake occurs, but o_gpr_wr_en stays 0. o_busy is unchanged.
- Scoreboard: issue id=7 -> o_busy[7]=1.
  - Then req0 writes id=7 -> o_busy[7]=0 one cycle after o_gpr_wr_en=1 is seen.
  - Issue id=7 on the same cycle that the id=7 write commits -> o_busy[7] stays 1.
- Reset mid-op: assert i_rst_n=0 in the cycle after a handshake on id=9 with o_busy[9]=1 -> next cycle o_gpr_wr_en=0 and o_busy=0. After release, requester 0 has priority.
